data_mem_responder: RTL

//  Responder side of the load/store-buffer data port. Accepts one byte/half/word request at a time.

---
 rtl/dmr_pkg.sv | 26 ++
 rtl/dmr_byte_lane.sv | 24 ++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmr_pkg.sv
// Shared encodings for data_mem_responder: access sizes, FSM states and the
// access-size to byte-count helper.
package dmr_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10,
    ACC_WORD = 2'b11
  } acc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  function automatic logic [2:0] len_of(input logic [1:0] acc);
    case (acc)
      ACC_HALF: return 3'd2;
      ACC_WORD: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmr_byte_lane.sv
// Combinational byte-lane helper: picks store byte sel_idx from a word and
// inserts a load byte into lane wr_idx of the assembled load word.
module dmr_byte_lane (
  input  logic [31:0] data_i,
  input  logic [1:0]  sel_idx_i,
  output logic [7:0]  sel_byte_o,
  input  logic [31:0] word_i,
  input  logic [1:0]  wr_idx_i,
  input  logic [7:0]  wr_byte_i,
  input  logic        wr_en_i,
  output logic [3:0]  lane_we_o,
  output logic [31:0] word_o
);

  always_comb begin
    sel_byte_o = data_i[{sel_idx_i, 3'b000} +: 8];
    lane_we_o  = 4'b0000;
    if (wr_en_i) lane_we_o[wr_idx_i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      word_o[8*k +: 8] = lane_we_o[k] ? wr_byte_i : word_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Serialises byte/half/word load-store requests onto a byte-wide RAM bus.
// Optional IO write back-pressure is enabled with `define DMR_IO_STALL_EN.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_SEL     = 2'b11
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clearIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddrIn,
  input  logic [31:0]           dataIn,
  output logic                  dataValid,
  output logic [31:0]           dataOut,
  output logic                  dataWriteSuc,
  output logic                  busy,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
`ifdef DMR_IO_STALL_EN
  input  logic                  ioBufferFull,
`endif
  output state_e                fsmState
);

  // Handshake: a request is a one-cycle accessType strobe, taken only on an
  // edge where the FSM is idle and clearIn is low; completion is a one-cycle
  // dataValid (load) or dataWriteSuc (store) pulse, during which busy is low.
  state_e                state_q;
  logic [2:0]            cnt_q, len_q;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr_q;
  logic [31:0]           data_q, dout_q;
  logic [7:0]            mem_out_q;
  logic                  valid_q, wsuc_q, busy_q, mem_we_q;

  logic [ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic [7:0]            st_byte;
  logic [3:0]            lane_we;
  logic [31:0]           ins_word;
  logic                  io_stall;

  assign rd_addr_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
  assign wr_addr_d = addr_q + ADDR_WIDTH'(cnt_q);

`ifdef DMR_IO_STALL_EN
  assign io_stall = (addr_q[17:16] == IO_SEL) && ioBufferFull;
`else
  assign io_stall = 1'b0;
`endif

  // Load byte seen now belongs to the address issued one cycle earlier.
  dmr_byte_lane u_lane (
    .data_i     (data_q),
    .sel_idx_i  (cnt_q[1:0]),
    .sel_byte_o (st_byte),
    .word_i     (dout_q),
    .wr_idx_i   (cnt_q[1:0] - 2'd1),
    .wr_byte_i  (memIn),
    .wr_en_i    ((state_q == ST_READ) && (cnt_q != 3'd0)),
    .lane_we_o  (lane_we),
    .word_o     (ins_word)
  );

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      mem_we_q   <= 1'b0;
      valid_q    <= 1'b0;
      wsuc_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      wsuc_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!clearIn && accessType != ACC_NONE) begin
            addr_q <= dataAddrIn;
            data_q <= dataIn;
            len_q  <= len_of(accessType);
            cnt_q  <= 3'd0;
            busy_q <= 1'b1;
            if (readWriteIn) begin
              state_q    <= ST_READ;
              mem_addr_q <= dataAddrIn;
              dout_q     <= '0;
            end else begin
              state_q <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (clearIn) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (|lane_we) dout_q <= ins_word;
            if (cnt_q == len_q) begin
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              if (cnt_q + 3'd1 < len_q) mem_addr_q <= rd_addr_d;
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          // A committed store always completes; clearIn is not looked at here.
          if (cnt_q == len_q) begin
            mem_we_q <= 1'b0;
            wsuc_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (io_stall) begin
            mem_we_q <= 1'b0;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr_d;
            mem_out_q  <= st_byte;
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dataValid    = valid_q;
  assign dataWriteSuc = wsuc_q;
  assign dataOut      = dout_q;
  assign busy         = busy_q;
  assign memOut       = mem_out_q;
  assign memAddr      = mem_addr_q;
  assign memWrite     = mem_we_q;
  assign fsmState     = state_q;

endmodule
